multi_run_detector: RTL and testbench

Parametrised, multi-channel run-length detector: the successor to the fixed 2-of-a-kind serial FSM detector. Each of NUM_CH serial bit-streams drives its own four-state Moore FSM. The FSM flags when a run of RUN_LEN consecutive valid samples equal to a selectable polarity is seen. Flags can be single-cycle pulses or held levels, and a shared saturating hit counter is kept for status/telemetry. The block sits between the per-lane sampled inputs and the event/interrupt logic.

---
 rtl/multi_run_detector.sv | 195 +++++++++++++++++++
 tb/tb_multi_run_detector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_run_detector.sv
// multi_run_detector
// Multi-channel run-length detector. Every channel runs its own Moore FSM
// (IDLE -> RUN -> HIT -> HOLD). A channel flags a hit when it sees RUN_LEN
// consecutive valid samples equal to the selected polarity. The flag is either
// a one-cycle pulse (HIT only) or a held level (HIT or HOLD). A shared
// saturating counter totals hit events across all channels.
module multi_run_detector #(
    parameter int NUM_CH  = 4,
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] in,
    input  logic              in_valid,
    input  logic              polarity,
    input  logic              level_mode,
    input  logic              clr_cnt,
    output logic [NUM_CH-1:0] out,
    output logic [CNT_W-1:0]  hit_cnt
);

    // Run counter must hold the values 0..RUN_LEN.
    localparam int RC_W  = $clog2(RUN_LEN + 1);
    // Per-cycle hit sum holds 0..NUM_CH.
    localparam int SUM_W = $clog2(NUM_CH + 1);
    // Widened accumulator so the saturating add can never wrap.
    localparam int ACC_W = CNT_W + SUM_W;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [RC_W-1:0]  RC_ONE      = RC_W'(1);
    localparam logic [RC_W-1:0]  RC_RUN_LEN  = RC_W'(RUN_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HIT  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Shared polarity tracking
    // ------------------------------------------------------------------
    logic pol_q_reg;
    logic pol_change;

    // Registered copy of polarity; a change restarts every channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            pol_q_reg <= 1'b1;
        end else begin
            pol_q_reg <= polarity;
        end
    end

    // On a polarity change edge the samples are discarded, so it suppresses
    // both match and miss below.
    assign pol_change = (polarity != pol_q_reg);

    // ------------------------------------------------------------------
    // Per-channel FSMs
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] hit_flag;
    logic [NUM_CH-1:0] hold_flag;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t          state_reg;
            state_t          state_next;
            logic [RC_W-1:0] rc_reg;
            logic [RC_W-1:0] rc_next;
            logic [RC_W-1:0] rc_plus;
            logic            match;
            logic            miss;

            assign match   = in_valid & ~pol_change & (in[gi] == pol_q_reg);
            assign miss    = in_valid & ~pol_change & (in[gi] != pol_q_reg);
            assign rc_plus = rc_reg + RC_ONE;

            // State and run counter registers for this channel.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= S_IDLE;
                    rc_reg    <= '0;
                end else begin
                    state_reg <= state_next;
                    rc_reg    <= rc_next;
                end
            end

            // Next-state logic; an invalid cycle freezes everything except
            // HIT, which always moves on so a pulse lasts a single cycle.
            always_comb begin
                state_next = state_reg;
                rc_next    = rc_reg;
                if (pol_change) begin
                    state_next = S_IDLE;
                    rc_next    = '0;
                end else begin
                    case (state_reg)
                        S_IDLE: begin
                            if (match) begin
                                rc_next    = RC_ONE;
                                state_next = (RUN_LEN == 1) ? S_HIT : S_RUN;
                            end
                        end
                        S_RUN: begin
                            if (match) begin
                                rc_next    = rc_plus;
                                state_next = (rc_plus == RC_RUN_LEN) ? S_HIT : S_RUN;
                            end else if (miss) begin
                                rc_next    = '0;
                                state_next = S_IDLE;
                            end
                        end
                        S_HIT: begin
                            if (miss) begin
                                rc_next    = '0;
                                state_next = S_IDLE;
                            end else begin
                                state_next = S_HOLD;
                            end
                        end
                        S_HOLD: begin
                            // rc stays at RUN_LEN while holding; it never wraps.
                            if (miss) begin
                                rc_next    = '0;
                                state_next = S_IDLE;
                            end
                        end
                        default: begin
                            rc_next    = '0;
                            state_next = S_IDLE;
                        end
                    endcase
                end
            end

            // Moore decode of the registered state.
            always_comb begin
                hit_flag[gi]  = (state_reg == S_HIT);
                hold_flag[gi] = (state_reg == S_HOLD);
            end
        end
    endgenerate

    // Output mode is applied combinationally so it takes effect immediately.
    always_comb begin
        if (level_mode) begin
            out = hit_flag | hold_flag;
        end else begin
            out = hit_flag;
        end
    end

    // ------------------------------------------------------------------
    // Shared saturating hit counter
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] hit_sum;
    logic [ACC_W-1:0] cnt_wide;
    logic [CNT_W-1:0] hit_cnt_reg;
    logic [CNT_W-1:0] hit_cnt_next;

    // Number of channels sitting in HIT this cycle.
    always_comb begin
        hit_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit_sum = hit_sum + SUM_W'(hit_flag[c]);
        end
    end

    // Saturating accumulate; clear overrides any hits on the same edge.
    always_comb begin
        cnt_wide = ACC_W'(hit_cnt_reg) + ACC_W'(hit_sum);
        if (clr_cnt) begin
            hit_cnt_next = '0;
        end else if (cnt_wide > ACC_W'(CNT_MAX)) begin
            hit_cnt_next = CNT_MAX;
        end else begin
            hit_cnt_next = cnt_wide[CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg <= '0;
        end else begin
            hit_cnt_reg <= hit_cnt_next;
        end
    end

    assign hit_cnt = hit_cnt_reg;

endmodule

// File: tb/tb_multi_run_detector.sv
// Testbench for multi_run_detector. Three instances with different
// parameters share the control inputs; a behavioural model tracks, per
// channel, the length of the current matching run and whether this edge
// just completed it, and derives flags and counts from that.
module tb_multi_run_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       polarity;
    logic       level_mode;
    logic       clr_cnt;
    logic [3:0] din;

    logic [3:0] out_a;
    logic [1:0] out_b;
    logic [0:0] out_c;
    logic [7:0] cnt_a;
    logic [2:0] cnt_b;
    logic [2:0] cnt_c;

    int errors = 0;
    int checks = 0;
    int step_no = 0;

    // Model state: index 0 = dut_a, 1 = dut_b, 2 = dut_c.
    int run_m  [3][4];
    bit just_m [3][4];
    bit pol_m  [3];
    int cnt_m  [3];

    always #5 clk = ~clk;

    multi_run_detector #(.NUM_CH(4), .RUN_LEN(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
        .polarity(polarity), .level_mode(level_mode), .clr_cnt(clr_cnt),
        .out(out_a), .hit_cnt(cnt_a)
    );

    multi_run_detector #(.NUM_CH(2), .RUN_LEN(3), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .in(din[1:0]), .in_valid(in_valid),
        .polarity(polarity), .level_mode(level_mode), .clr_cnt(clr_cnt),
        .out(out_b), .hit_cnt(cnt_b)
    );

    multi_run_detector #(.NUM_CH(1), .RUN_LEN(1), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .in(din[0:0]), .in_valid(in_valid),
        .polarity(polarity), .level_mode(level_mode), .clr_cnt(clr_cnt),
        .out(out_c), .hit_cnt(cnt_c)
    );

    function automatic int nc(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    function automatic int rl(input int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : 1;
    endfunction

    function automatic int cmax(input int k);
        return (k == 0) ? 255 : 7;
    endfunction

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        int hits;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                for (int c = 0; c < 4; c++) begin
                    run_m[k][c]  = 0;
                    just_m[k][c] = 1'b0;
                end
                pol_m[k] = 1'b1;
                cnt_m[k] = 0;
            end else begin
                hits = 0;
                for (int c = 0; c < nc(k); c++) hits += int'(just_m[k][c]);
                if (clr_cnt) cnt_m[k] = 0;
                else if (cnt_m[k] + hits > cmax(k)) cnt_m[k] = cmax(k);
                else cnt_m[k] = cnt_m[k] + hits;

                if (polarity != pol_m[k]) begin
                    for (int c = 0; c < 4; c++) begin
                        run_m[k][c]  = 0;
                        just_m[k][c] = 1'b0;
                    end
                    pol_m[k] = polarity;
                end else begin
                    for (int c = 0; c < nc(k); c++) begin
                        if (!in_valid) begin
                            just_m[k][c] = 1'b0;
                        end else if (din[c] == pol_m[k]) begin
                            if (run_m[k][c] < rl(k)) begin
                                run_m[k][c]  = run_m[k][c] + 1;
                                just_m[k][c] = (run_m[k][c] == rl(k));
                            end else begin
                                just_m[k][c] = 1'b0;
                            end
                        end else begin
                            run_m[k][c]  = 0;
                            just_m[k][c] = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    // Compare every instance's outputs against the model.
    task automatic check_all();
        logic [31:0] exp_out;
        logic [31:0] obs_out;
        logic [31:0] obs_cnt;
        for (int k = 0; k < 3; k++) begin
            exp_out = '0;
            for (int c = 0; c < nc(k); c++) begin
                if (level_mode ? (run_m[k][c] >= rl(k)) : just_m[k][c])
                    exp_out[c] = 1'b1;
            end
            obs_out = (k == 0) ? 32'(out_a) : (k == 1) ? 32'(out_b) : 32'(out_c);
            obs_cnt = (k == 0) ? 32'(cnt_a) : (k == 1) ? 32'(cnt_b) : 32'(cnt_c);
            check_eq($sformatf("out_%0d", k), obs_out, exp_out);
            check_eq($sformatf("hit_cnt_%0d", k), obs_cnt, 32'(cnt_m[k]));
        end
    endtask

    // Drive one transaction, clock it, update the model and compare.
    task automatic step(input logic [3:0] d, input logic v);
        din      = d;
        in_valid = v;
        @(posedge clk);
        model_edge();
        #1;
        step_no++;
        $display("step %0d rst=%b din=%h v=%b pol=%b lvl=%b clr=%b | out_a=%h cnt_a=%0d out_b=%h cnt_b=%0d out_c=%h cnt_c=%0d",
                 step_no, rst, d, v, polarity, level_mode, clr_cnt,
                 out_a, cnt_a, out_b, cnt_b, out_c, cnt_c);
        check_all();
    endtask

    logic [7:0] cnt_before;
    logic [3:0] rnd;
    logic [3:0] legacy_seq;
    logic [7:0] legacy_bits;

    initial begin
        rst = 1'b1; in_valid = 1'b0; polarity = 1'b1;
        level_mode = 1'b0; clr_cnt = 1'b0; din = 4'h0;

        // Reset state.
        step(4'h0, 1'b0);
        step(4'hF, 1'b1);
        check_eq("reset_out_a", 32'(out_a), 32'h0);
        check_eq("reset_cnt_a", 32'(cnt_a), 32'h0);
        rst = 1'b0;

        // Legacy sequence on channel 0: 0,1,1,1,1,0,1,1.
        legacy_bits = 8'b1101_1110;  // bit i = sample i
        for (int i = 0; i < 8; i++) begin
            step({3'b000, legacy_bits[i]}, 1'b1);
            if (i == 2) check_eq("legacy_pulse1", 32'(out_a), 32'h1);
            if (i == 3) check_eq("legacy_no_repeat", 32'(out_a), 32'h0);
            if (i == 7) check_eq("legacy_pulse2", 32'(out_a), 32'h1);
        end
        step(4'h0, 1'b0);
        check_eq("legacy_cnt", 32'(cnt_a), 32'd2);

        // Level mode with gaps on dut_b (RUN_LEN=3).
        level_mode = 1'b1;
        step(4'h0, 1'b1);
        step(4'h3, 1'b1);
        step(4'h3, 1'b1);
        step(4'h3, 1'b0);
        step(4'h3, 1'b0);
        check_eq("gap_not_yet", 32'(out_b), 32'h0);
        step(4'h3, 1'b1);
        check_eq("gap_rise", 32'(out_b), 32'h3);
        step(4'h3, 1'b1);
        check_eq("gap_hold", 32'(out_b), 32'h3);
        step(4'h0, 1'b1);
        check_eq("gap_fall", 32'(out_b), 32'h0);

        // Zero-run polarity: channel 2 sees 0,0.
        level_mode = 1'b0;
        polarity = 1'b0;
        step(4'hF, 1'b1);                 // polarity-change edge, samples ignored
        step(4'hB, 1'b1);
        step(4'hB, 1'b1);
        check_eq("pol0_ch2_hit", 32'(out_a), 32'h4);

        // Toggle polarity mid-run: the partial run is discarded.
        step(4'hF, 1'b1);
        step(4'h0, 1'b1);                 // one matching sample
        polarity = 1'b1;
        step(4'h0, 1'b1);
        polarity = 1'b0;
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        check_eq("toggle_discard", 32'(out_a), 32'h0);
        step(4'h0, 1'b1);
        check_eq("all_ch_hit", 32'(out_a), 32'hF);
        cnt_before = cnt_a;
        step(4'h0, 1'b0);
        check_eq("all_ch_cnt", 32'(cnt_a), 32'(cnt_before) + 32'd4);

        // Saturation on dut_c (CNT_W=3, RUN_LEN=1): nine hits.
        polarity = 1'b1;
        clr_cnt = 1'b1;
        step(4'h0, 1'b1);
        clr_cnt = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(4'h1, 1'b1);
            step(4'h0, 1'b1);
        end
        check_eq("sat_cnt_c", 32'(cnt_c), 32'd7);

        // Clear wins over a simultaneous hit.
        step(4'h1, 1'b1);
        clr_cnt = 1'b1;
        step(4'h0, 1'b1);
        check_eq("clr_wins", 32'(cnt_c), 32'd0);
        clr_cnt = 1'b0;

        // Reset while holding, and level mode switched without an edge.
        step(4'h1, 1'b1);
        step(4'h1, 1'b1);
        check_eq("hold_pulse_off", 32'(out_c), 32'h0);
        level_mode = 1'b1;
        #1;
        check_all();
        check_eq("hold_level_on", 32'(out_c), 32'h1);
        rst = 1'b1;
        step(4'h1, 1'b1);
        check_eq("rst_hold_out", 32'(out_c), 32'h0);
        check_eq("rst_hold_cnt", 32'(cnt_c), 32'h0);
        rst = 1'b0;
        step(4'h1, 1'b1);
        check_eq("post_rst_hit", 32'(out_c), 32'h1);

        // Randomised traffic, biased toward matching samples.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) polarity = ~polarity;
            level_mode = 1'($urandom_range(0, 1));
            clr_cnt    = ($urandom_range(0, 29) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < 4; c++)
                rnd[c] = ($urandom_range(0, 3) != 0) ? polarity : ~polarity;
            step(rnd, ($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        clr_cnt = 1'b0;
        step(4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
